// File: rtl/mult_arbiter.sv
// Round-robin arbiter/sequencer sharing one shift-based multiplier datapath among N requesters.
// One-hot FSM IDLE->GRANT->START->WAIT->RESP; a watchdog aborts WAIT after TIMEOUT cycles.
module mult_arbiter #(
  parameter int N       = 4,
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N*WIDTH-1:0]   a_in,
  input  logic [N*WIDTH-1:0]   b_in,
  output logic [N-1:0]         gnt,
  output logic [N-1:0]         res_valid,
  output logic [2*WIDTH-1:0]   res_out,
  output logic                 err,
  output logic                 busy,
  output logic                 mul_start,
  output logic [WIDTH-1:0]     mul_a,
  output logic [WIDTH-1:0]     mul_b,
  input  logic                 mul_done,
  input  logic [2*WIDTH-1:0]   mul_result
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_GRANT = 5'b00010,
    S_START = 5'b00100,
    S_WAIT  = 5'b01000,
    S_RESP  = 5'b10000
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [IW-1:0]      r_ptr;
  logic [IW-1:0]      r_sel;
  logic [IW-1:0]      w_win;
  logic [CW-1:0]      r_cnt;
  logic               w_timeout;
  logic [WIDTH-1:0]   r_mul_a;
  logic [WIDTH-1:0]   r_mul_b;
  logic [2*WIDTH-1:0] r_res;
  logic               r_err;

  assign w_timeout = (r_cnt == CW'(TIMEOUT - 1));

  // Scan from farthest to nearest so the requester closest after r_ptr wins.
  always_comb begin
    w_win = r_ptr;
    for (int off = N; off >= 1; off--) begin
      if (req[(int'(r_ptr) + off) % N]) begin
        w_win = IW'((int'(r_ptr) + off) % N);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (|req) w_next = S_GRANT;
      S_GRANT: w_next = S_START;
      S_START: w_next = S_WAIT;
      S_WAIT:  if (mul_done || w_timeout) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ptr   <= IW'(N - 1);
      r_sel   <= '0;
      r_cnt   <= '0;
      r_mul_a <= '0;
      r_mul_b <= '0;
      r_res   <= '0;
      r_err   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (|req) r_sel <= w_win;
        end
        S_GRANT: begin
          r_mul_a <= a_in[int'(r_sel)*WIDTH +: WIDTH];
          r_mul_b <= b_in[int'(r_sel)*WIDTH +: WIDTH];
          r_ptr   <= r_sel;
        end
        S_START: begin
          r_cnt <= '0;
        end
        S_WAIT: begin
          if (mul_done) begin
            r_res <= mul_result;
            r_err <= 1'b0;
          end else if (w_timeout) begin
            r_res <= '0;
            r_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Pulses are decoded from the registered one-hot state, so no input reaches an output.
  always_comb begin
    gnt       = '0;
    res_valid = '0;
    if (r_state == S_GRANT) gnt[r_sel]       = 1'b1;
    if (r_state == S_RESP)  res_valid[r_sel] = 1'b1;
  end

  assign mul_start = (r_state == S_START);
  assign busy      = (r_state != S_IDLE);
  assign mul_a     = r_mul_a;
  assign mul_b     = r_mul_b;
  assign res_out   = r_res;
  assign err       = r_err;

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter: bench-side datapath stub plus round-robin reference model.
module tb_mult_arbiter;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int TO = 64;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] a_in;
  logic [N*W-1:0] b_in;
  logic [N-1:0]   gnt;
  logic [N-1:0]   res_valid;
  logic [2*W-1:0] res_out;
  logic           err;
  logic           busy;
  logic           mul_start;
  logic [W-1:0]   mul_a;
  logic [W-1:0]   mul_b;
  logic           mul_done;
  logic [2*W-1:0] mul_result;

  int checks = 0;
  int errors = 0;

  mult_arbiter #(.N(N), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .res_valid(res_valid), .res_out(res_out), .err(err), .busy(busy),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(mul_done), .mul_result(mul_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    a_in[i*W +: W] = a;
    b_in[i*W +: W] = b;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; req = '0; mul_done = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Called at a negedge with req already driven (that IDLE cycle is cycle 0).
  // Plays the datapath: mul_done is seen in cycle ts+1+lat (lat<0 = never).
  // Returns at the negedge of the IDLE cycle following RESP.
  task automatic run_txn(input int lat, input bit hold, input bit stray,
                         output logic [N-1:0] g, output int tg, output int ts, output int tv,
                         output logic [N-1:0] rv, output logic [2*W-1:0] ro, output logic e,
                         output bit glitch, output logic idle_busy);
    int ng, ns, nv, act;
    g = '0; rv = '0; ro = '0; e = 1'b0; glitch = 1'b0; idle_busy = 1'bx;
    tg = -1; ts = -1; tv = -1; ng = 0; ns = 0; nv = 0;
    for (int c = 1; c <= 200 && tv < 0; c++) begin
      @(negedge clk);
      mul_done = 1'b0;
      act = int'(gnt != '0) + int'(mul_start) + int'(res_valid != '0);
      if (act > 1) glitch = 1'b1;
      if (gnt != '0) begin
        ng++; g = gnt; tg = c;
        if (!$onehot(gnt)) glitch = 1'b1;
        if (!hold) req = req & ~gnt;
      end
      if (mul_start) begin ns++; ts = c; end
      if (res_valid != '0) begin nv++; rv = res_valid; tv = c; ro = res_out; e = err; end
      if (stray && ts == c) begin mul_done = 1'b1; mul_result = '1; end
      if (lat >= 0 && ts >= 0 && c == ts + 1 + lat) begin
        mul_done = 1'b1;
        mul_result = (2*W)'(mul_a) * (2*W)'(mul_b);
      end
    end
    mul_done = 1'b0;
    if (tv >= 0) begin
      @(negedge clk);
      idle_busy = busy;
      if (res_valid != '0 || gnt != '0 || mul_start) glitch = 1'b1;
      if (ng != 1 || ns != 1 || nv != 1) glitch = 1'b1;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if ({gnt, res_valid, mul_start, busy} !== '0) begin errors++;
      $display("FAIL reset_pulses: gnt=%b rv=%b start=%b busy=%b required all 0", gnt, res_valid, mul_start, busy); end
    checks++; if ({res_out, err} !== '0) begin errors++;
      $display("FAIL reset_result: res_out=%0h err=%b required 0", res_out, err); end
    checks++; if ({mul_a, mul_b} !== '0) begin errors++;
      $display("FAIL reset_operands: mul_a=%0h mul_b=%0h required 0", mul_a, mul_b); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++;
      $display("FAIL reset_idle: busy=%b required 0", busy); end
  endtask

  task automatic test_single();
    logic [N-1:0] g, rv; logic [2*W-1:0] ro; logic e, ib; int tg, ts, tv; bit gl;
    set_op(0, 16'd3, 16'd5);
    req = 4'b0001;
    run_txn(8, 1'b0, 1'b0, g, tg, ts, tv, rv, ro, e, gl, ib);
    checks++; if (g !== 4'b0001 || tg != 1) begin errors++;
      $display("FAIL single_gnt: gnt=%b at %0d required 0001 at 1", g, tg); end
    checks++; if (ts != 2) begin errors++;
      $display("FAIL single_start: cycle %0d required 2", ts); end
    checks++; if (tv != 12 || rv !== 4'b0001) begin errors++;
      $display("FAIL single_valid: rv=%b at %0d required 0001 at 12", rv, tv); end
    checks++; if (ro !== 32'd15 || e !== 1'b0) begin errors++;
      $display("FAIL single_result: res=%0d err=%b required 15 err 0", ro, e); end
    checks++; if (gl || ib !== 1'b0) begin errors++;
      $display("FAIL single_pulses: glitch=%0d busy_after=%b required 0 0", gl, ib); end
  endtask

  task automatic test_simultaneous();
    logic [N-1:0] g, rv; logic [2*W-1:0] ro; logic e, ib; int tg, ts, tv; bit gl;
    do_reset();
    set_op(1, 16'd7, 16'd9);
    set_op(2, 16'd2, 16'd11);
    req = 4'b0110;
    run_txn($urandom_range(0, 6), 1'b0, 1'b0, g, tg, ts, tv, rv, ro, e, gl, ib);
    checks++; if (g !== 4'b0010 || rv !== 4'b0010 || ro !== 32'd63) begin errors++;
      $display("FAIL simul_first: gnt=%b rv=%b res=%0d required 0010 0010 63", g, rv, ro); end
    run_txn($urandom_range(0, 6), 1'b0, 1'b0, g, tg, ts, tv, rv, ro, e, gl, ib);
    checks++; if (g !== 4'b0100 || rv !== 4'b0100 || ro !== 32'd22 || gl) begin errors++;
      $display("FAIL simul_second: gnt=%b rv=%b res=%0d glitch=%0d required 0100 0100 22 0", g, rv, ro, gl); end
  endtask

  task automatic test_fairness();
    logic [N-1:0] g, rv, prev; logic [2*W-1:0] ro; logic e, ib; int tg, ts, tv; bit gl;
    logic [W-1:0] ea [N];
    logic [W-1:0] eb [N];
    int bad;
    do_reset();
    for (int i = 0; i < N; i++) begin
      ea[i] = W'($urandom); eb[i] = W'($urandom); set_op(i, ea[i], eb[i]);
    end
    req = 4'b1111; prev = '0; bad = 0;
    for (int k = 0; k < 8; k++) begin
      run_txn($urandom_range(0, 5), 1'b1, 1'b0, g, tg, ts, tv, rv, ro, e, gl, ib);
      if (g !== 4'(1 << (k % N)) || g === prev || rv !== g || gl ||
          ro !== (2*W)'(ea[k % N]) * (2*W)'(eb[k % N])) begin
        bad++;
        $display("FAIL fairness_%0d: gnt=%b res=%0h required gnt=%b", k, g, ro, 4'(1 << (k % N)));
      end
      prev = g;
      ea[k % N] = W'($urandom); eb[k % N] = W'($urandom); set_op(k % N, ea[k % N], eb[k % N]);
    end
    req = '0;
    checks++; if (bad != 0) begin errors++;
      $display("FAIL fairness: %0d bad transactions required 0", bad); end
  endtask

  task automatic test_timeout();
    logic [N-1:0] g, rv; logic [2*W-1:0] ro; logic e, ib; int tg, ts, tv; bit gl;
    set_op(2, 16'd1234, 16'd77);
    req = 4'b0100;
    run_txn(-1, 1'b0, 1'b0, g, tg, ts, tv, rv, ro, e, gl, ib);
    checks++; if (tv != 3 + TO || rv !== 4'b0100) begin errors++;
      $display("FAIL timeout_valid: rv=%b at %0d required 0100 at %0d", rv, tv, 3 + TO); end
    checks++; if (e !== 1'b1 || ro !== '0) begin errors++;
      $display("FAIL timeout_result: err=%b res=%0h required 1 0", e, ro); end
    checks++; if (ib !== 1'b0 || gl) begin errors++;
      $display("FAIL timeout_idle: busy=%b glitch=%0d required 0 0", ib, gl); end
  endtask

  task automatic test_reset_mid_wait();
    logic [N-1:0] g, rv; logic [2*W-1:0] ro; logic e, ib; int tg, ts, tv; bit gl;
    int bad;
    set_op(0, 16'd300, 16'd41);
    req = 4'b0001;
    run_txn(2, 1'b0, 1'b0, g, tg, ts, tv, rv, ro, e, gl, ib);
    req = 4'b0001;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) req = '0;
    end
    checks++; if (busy !== 1'b1 || mul_a !== 16'd300) begin errors++;
      $display("FAIL midwait_pre: busy=%b mul_a=%0d required 1 300", busy, mul_a); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if ({gnt, res_valid, mul_start, busy, err, res_out, mul_a, mul_b} !== '0) begin errors++;
      $display("FAIL midwait_reset: gnt=%b rv=%b busy=%b res=%0h mul_a=%0h required all 0",
               gnt, res_valid, busy, res_out, mul_a); end
    rst = 1'b1; bad = 0;
    for (int c = 0; c < 6; c++) begin
      mul_done = c[0]; mul_result = 32'hdeadbeef;
      @(negedge clk);
      if (res_valid !== '0 || busy !== 1'b0) bad++;
    end
    mul_done = 1'b0;
    checks++; if (bad != 0) begin errors++;
      $display("FAIL midwait_quiet: %0d cycles with activity required 0", bad); end
    set_op(0, 16'd6, 16'd7);
    set_op(1, 16'd8, 16'd9);
    req = 4'b0011;
    run_txn(3, 1'b0, 1'b0, g, tg, ts, tv, rv, ro, e, gl, ib);
    checks++; if (g !== 4'b0001 || ro !== 32'd42) begin errors++;
      $display("FAIL midwait_regrant: gnt=%b res=%0d required 0001 42", g, ro); end
    req = '0;
  endtask

  task automatic test_stray_done();
    logic [N-1:0] g, rv; logic [2*W-1:0] ro; logic e, ib; int tg, ts, tv; bit gl;
    int bad;
    req = '0; bad = 0;
    repeat (3) begin
      mul_done = 1'b1; mul_result = '1;
      @(negedge clk);
      if (busy !== 1'b0 || res_valid !== '0) bad++;
    end
    mul_done = 1'b0;
    checks++; if (bad != 0) begin errors++;
      $display("FAIL stray_idle: %0d cycles with activity required 0", bad); end
    set_op(3, 16'hffff, 16'h0003);
    req = 4'b1000;
    run_txn(3, 1'b0, 1'b1, g, tg, ts, tv, rv, ro, e, gl, ib);
    checks++; if (tv != 7 || rv !== 4'b1000 || ro !== 32'h0002fffd || e !== 1'b0 || gl) begin errors++;
      $display("FAIL stray_start: rv=%b at %0d res=%0h err=%b required 1000 at 7 2fffd 0", rv, tv, ro, e); end
  endtask

  task automatic test_random();
    logic [N-1:0] g, rv, m, eg; logic [2*W-1:0] ro; logic e, ib; int tg, ts, tv; bit gl;
    logic [W-1:0] ea [N];
    logic [W-1:0] eb [N];
    int mptr, win, lat, bad;
    do_reset();
    mptr = N - 1; bad = 0;
    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < N; i++) begin
        ea[i] = W'($urandom); eb[i] = W'($urandom); set_op(i, ea[i], eb[i]);
      end
      m = 4'($urandom_range(1, 15));
      win = -1;
      for (int off = 1; off <= N && win < 0; off++)
        if (m[(mptr + off) % N]) win = (mptr + off) % N;
      eg = 4'(1 << win);
      lat = $urandom_range(0, 10);
      req = m;
      run_txn(lat, 1'b0, 1'b0, g, tg, ts, tv, rv, ro, e, gl, ib);
      if (g !== eg || rv !== eg || e !== 1'b0 || gl || tv - ts != lat + 2 ||
          ro !== (2*W)'(ea[win]) * (2*W)'(eb[win])) begin
        bad++;
        $display("FAIL random_%0d: req=%b gnt=%b res=%0h required gnt=%b res=%0h",
                 k, m, g, ro, eg, (2*W)'(ea[win]) * (2*W)'(eb[win]));
      end
      mptr = win;
    end
    req = '0;
    checks++; if (bad != 0) begin errors++;
      $display("FAIL random: %0d bad transactions required 0", bad); end
  endtask

  initial begin
    rst = 1'b0; req = '0; a_in = '0; b_in = '0; mul_done = 1'b0; mul_result = '0;
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_timeout();
    test_reset_mid_wait();
    test_stray_done();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
